// File: rtl/ram_dumper_pkg.sv
// Shared constants for the RAM dumper: FSM encodings and byte geometry.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ram_dumper_pkg;

    localparam int BYTE_W = 8;
    localparam int ST_W   = 3;

    // FSM encodings, kept as plain constants so older tools and scripts can decode them
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_READ = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_SEND = 3'd3;
    localparam logic [ST_W-1:0] ST_FIN  = 3'd4;

    // Width of a byte index for a word of nbytes bytes (at least one bit)
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/ram_dumper_word_serializer.sv
// Word-to-byte serializer: loads one RAM word and emits it LSB byte first.
// Latency: first byte valid the cycle after load; one byte per cycle with ready high.
// Backpressure: tx_data/tx_valid hold while tx_valid && !tx_ready.
module word_serializer
    import ram_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_res,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  active,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  last_fire
);

    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam int IDX_W  = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      idx;
    logic                  fire;

    assign tx_valid  = active;
    assign fire      = active && tx_ready;
    assign last_fire = fire && (idx == LAST_IDX);
    // The current byte always sits in the low lane; the register shifts on each handshake
    assign tx_data   = shreg[7:0];

    // Word capture and per-handshake shift/index advance
    always_ff @(posedge sys_clk or negedge sys_res) begin
        if (!sys_res) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load) begin
            shreg <= load_data;
            idx   <= '0;
        end else if (fire) begin
            shreg <= shreg >> BYTE_W;
            idx   <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/ram_dumper.sv
// Dumps word_count RAM words starting at base_addr as a byte stream, LSB first.
// Latency: 6 cycles per word with tx_ready high (READ, WAIT, 4 x SEND), then one FIN cycle.
// Backpressure: tx_ready low stalls SEND with tx_data/tx_valid held stable.
module ram_dumper
    import ram_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_res,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    logic [ST_W-1:0]       state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    // One bit wider than the address so a full-RAM dump (2^ADDR_WIDTH words) fits
    logic [ADDR_WIDTH:0]   remaining;
    logic                  word_sent;

    assign ram_re   = (state == ST_READ);
    assign ram_addr = addr_cnt;
    assign done     = (state == ST_FIN);
    assign busy     = (state == ST_READ) || (state == ST_WAIT) || (state == ST_SEND);

    word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .sys_clk   (sys_clk),
        .sys_res   (sys_res),
        .load      (state == ST_WAIT),
        .load_data (ram_rdata),
        .active    (state == ST_SEND),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .last_fire (word_sent)
    );

    // Dump sequencer: start sampling, address walk (wraps naturally) and word countdown
    always_ff @(posedge sys_clk or negedge sys_res) begin
        if (!sys_res) begin
            state     <= ST_IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr_cnt  <= base_addr;
                            remaining <= word_count;
                            state     <= ST_READ;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_READ: state <= ST_WAIT;
                ST_WAIT: state <= ST_SEND;
                ST_SEND: begin
                    if (word_sent) begin
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                        state     <= (remaining != (ADDR_WIDTH+1)'(1)) ? ST_READ : ST_FIN;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dumper.sv
// Self-checking bench for ram_dumper against a byte-stream reference model.
// Latency: n/a.
// Backpressure: tx_ready driven high, toggling or random per scenario.
module tb_ram_dumper;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          sys_clk;
    logic          sys_res;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic [DW-1:0] ram_rdata;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    ram_dumper #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_res    (sys_res),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous-read RAM: data valid the cycle after ram_re
    always @(posedge sys_clk) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one dump and checks it against the reference stream.
    // mode 0: tx_ready high, 1: toggling, 2: random. extra: pulse start again mid-dump.
    task automatic run_dump(input int base, input int cnt, input int mode, input bit extra);
        logic [7:0] exp_b[$];
        int         exp_a[$];
        int         nb, na, cyc, budget, a;
        bit         got_done, stall;
        logic [7:0] stall_dat;
        logic [DW-1:0] w;
        for (int i = 0; i < cnt; i++) begin
            a = (base + i) % DEPTH;
            exp_a.push_back(a);
            w = mem[a];
            for (int b = 0; b < DW/8; b++) exp_b.push_back(8'((w >> (8*b)) & 32'hFF));
        end
        @(negedge sys_clk);
        start      = 1'b1;
        base_addr  = AW'(base);
        word_count = (AW+1)'(cnt);
        tx_ready   = 1'b1;
        cyc = 0; nb = 0; na = 0; got_done = 1'b0; stall = 1'b0; stall_dat = '0;
        budget = 20 * cnt + 20;
        while (!got_done && cyc < budget) begin
            @(negedge sys_clk);
            cyc++;
            start = 1'b0;
            if (extra && cyc == 3) begin
                start      = 1'b1;
                base_addr  = ~AW'(base);
                word_count = (AW+1)'(1);
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall) begin
                check("stall_valid", 64'(tx_valid), 64'(1));
                check("stall_data", 64'(tx_data), 64'(stall_dat));
            end
            if (ram_re) begin
                check("read_in_range", 64'(na < exp_a.size()), 64'(1));
                if (na < exp_a.size()) check("ram_addr", 64'(ram_addr), 64'(exp_a[na]));
                na++;
            end
            if (tx_valid && tx_ready) begin
                check("byte_in_range", 64'(nb < exp_b.size()), 64'(1));
                if (nb < exp_b.size()) check("tx_data", 64'(tx_data), 64'(exp_b[nb]));
                nb++;
            end
            if (done) begin
                got_done = 1'b1;
                check("busy_at_done", 64'(busy), 64'(0));
            end else begin
                check("busy_during", 64'(busy), 64'(cnt != 0));
            end
            stall     = tx_valid && !tx_ready;
            stall_dat = tx_data;
        end
        check("done_seen", 64'(got_done), 64'(1));
        check("byte_count", 64'(nb), 64'(exp_b.size()));
        check("read_count", 64'(na), 64'(cnt));
        // done arrives in FIN, the cycle after the last SEND: 6 cycles per word plus one
        if (mode == 0) check("done_latency", 64'(cyc), 64'(6 * cnt + 1));
        @(negedge sys_clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [DW-1:0] w0;
        sys_res    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        tx_ready   = 1'b1;
        ram_rdata  = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;

        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ram_re", 64'(ram_re), 64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_ram_addr", 64'(ram_addr), 64'(0));
        @(negedge sys_clk);
        sys_res = 1'b1;
        @(negedge sys_clk);

        // Known two-word dump, full throughput
        run_dump(0, 2, 0, 1'b0);
        // Zero-length dump: no reads, no bytes
        run_dump(0, 0, 0, 1'b0);
        // Alternating backpressure
        run_dump(0, 2, 1, 1'b0);
        // Wrap across the top address
        run_dump(DEPTH - 1, 2, 0, 1'b0);
        // Start while busy is ignored
        run_dump(5, 3, 0, 1'b1);
        // Randomized dumps
        for (int k = 0; k < 8; k++)
            run_dump($urandom_range(0, DEPTH - 1), $urandom_range(1, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        // Reset during the second byte of the first word
        w0 = mem[0];
        @(negedge sys_clk);
        start      = 1'b1;
        base_addr  = '0;
        word_count = (AW+1)'(2);
        tx_ready   = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("mid_valid", 64'(tx_valid), 64'(1));
        check("mid_byte1", 64'(tx_data), 64'((w0 >> 8) & 32'hFF));
        #1 sys_res = 1'b0;
        #1;
        check("abort_tx_valid", 64'(tx_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_tx_data", 64'(tx_data), 64'(0));
        check("abort_ram_addr", 64'(ram_addr), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            check("abort_no_done", 64'(done), 64'(0));
        end
        sys_res = 1'b1;
        @(negedge sys_clk);
        run_dump(1, 1, 0, 1'b0);

        // Whole RAM exactly once
        run_dump($urandom_range(0, DEPTH - 1), DEPTH, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
